// File: rtl/adc0804_bcd_ctrl.sv
// ADC0804 conversion sequencer for the LM35 display path: runs the cs/wr/intr/rd handshake,
// scales the sampled code to tenths of a degree and converts it to packed BCD by double-dabble.
module adc0804_bcd_ctrl #(
    parameter int unsigned SAMPLE_PERIOD  = 5_000_000,
    parameter int unsigned WR_CYCLES      = 8,
    parameter int unsigned RD_CYCLES      = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100_000,
    parameter int unsigned LSB_TENTHS     = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  adc_data,
    input  logic        adc_intr_n,
    output logic        adc_cs_n,
    output logic        adc_wr_n,
    output logic        adc_rd_n,
    output logic [15:0] bcd,
    output logic        bcd_valid,
    output logic        busy,
    output logic        timeout
);

    localparam int unsigned BIN_W    = 14;
    localparam int unsigned BCD_W    = 16;
    localparam int unsigned SH_W     = BIN_W + BCD_W;
    localparam int unsigned DD_STEPS = BIN_W;
    localparam int unsigned SAT_MAX  = 9999;
    localparam int unsigned PER_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int unsigned MAX_AB   = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int unsigned MAX_ABC  = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX  = (MAX_ABC > DD_STEPS) ? MAX_ABC : DD_STEPS;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_INTR,
        READ,
        CONVERT,
        UPDATE
    } state_t;

    state_t             state;
    logic [PER_W-1:0]   per_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         intr_sync;
    logic [7:0]         code;
    logic [SH_W-1:0]    sh;
    logic [15:0]        prod;
    logic [BIN_W-1:0]   value;

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] s);
        logic [SH_W-1:0] t;
        t = s;
        for (int i = 0; i < 4; i++) begin
            if (t[BIN_W + 4*i +: 4] >= 4'd5) begin
                t[BIN_W + 4*i +: 4] = t[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
        return {t[SH_W-2:0], 1'b0};
    endfunction

    // Scaled reading in tenths of a degree, clamped to the four-digit display range.
    assign prod  = 16'(code) * 16'(LSB_TENTHS);
    assign value = (prod > 16'(SAT_MAX)) ? BIN_W'(SAT_MAX) : prod[BIN_W-1:0];

    // Free-running sample period counter, independent of the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            per_cnt <= '0;
        end else if (per_cnt == PER_W'(SAMPLE_PERIOD - 1)) begin
            per_cnt <= '0;
        end else begin
            per_cnt <= per_cnt + PER_W'(1);
        end
    end

    // INTR is asynchronous to clk; only intr_sync[1] is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intr_sync <= 2'b11;
        end else begin
            intr_sync <= {intr_sync[0], adc_intr_n};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            code      <= '0;
            sh        <= '0;
            adc_cs_n  <= 1'b1;
            adc_wr_n  <= 1'b1;
            adc_rd_n  <= 1'b1;
            bcd       <= '0;
            bcd_valid <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            bcd_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (per_cnt == '0) begin
                        state    <= START;
                        cnt      <= '0;
                        adc_cs_n <= 1'b0;
                        adc_wr_n <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_W'(WR_CYCLES - 1)) begin
                        state    <= WAIT_INTR;
                        cnt      <= '0;
                        adc_wr_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT_INTR: begin
                    if (!intr_sync[1]) begin
                        state    <= READ;
                        cnt      <= '0;
                        adc_rd_n <= 1'b0;
                    end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        // Abandon the conversion; the displayed value stays as it was.
                        state    <= IDLE;
                        cnt      <= '0;
                        adc_cs_n <= 1'b1;
                        busy     <= 1'b0;
                        timeout  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                READ: begin
                    if (cnt == CNT_W'(RD_CYCLES - 1)) begin
                        state    <= CONVERT;
                        cnt      <= '0;
                        code     <= adc_data;
                        adc_rd_n <= 1'b1;
                        adc_cs_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                CONVERT: begin
                    // First step loads the scaled value; BCD nibbles are zero so no correction applies.
                    sh <= dd_step((cnt == '0) ? {BCD_W'(0), value} : sh);
                    if (cnt == CNT_W'(DD_STEPS - 1)) begin
                        state <= UPDATE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                UPDATE: begin
                    state     <= IDLE;
                    bcd       <= sh[SH_W-1:BIN_W];
                    bcd_valid <= 1'b1;
                    busy      <= 1'b0;
                    timeout   <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    cnt      <= '0;
                    adc_cs_n <= 1'b1;
                    adc_wr_n <= 1'b1;
                    adc_rd_n <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc0804_bcd_ctrl.sv
// Bench for adc0804_bcd_ctrl: four instances (normal, 39 tenths/LSB, 40 tenths/LSB, short period)
// driven by a behavioural ADC0804 model, with a queue of expected BCD words.
module tb_adc0804_bcd_ctrl;

    localparam int unsigned N        = 4;
    localparam int unsigned PER      = 200;
    localparam int unsigned PER_FAST = 30;
    localparam int unsigned TMO      = 1000;
    localparam int unsigned ADC_DLY  = 50;
    localparam int unsigned LAT      = 2 + 24;

    typedef struct {
        int          idx;
        logic [15:0] val;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [7:0]     adc_data [N];
    logic [N-1:0]   intr_n = '1;
    logic [N-1:0]   cs_n, wr_n, rd_n, bcd_valid, busy, tmo;
    logic [15:0]    bcd [N];

    logic [N-1:0]   adc_en  = '0;
    logic [N-1:0]   wr_q    = '1;
    logic [N-1:0]   busy_q  = '0;
    logic [N-1:0]   valid_q = '0;
    logic           chk_fast = 1'b0;
    int             dly [N];
    int             wr_run [N], rd_run [N], wr_w [N], rd_w [N];
    int             t_intr [N], t_valid [N], valid_cnt [N];
    int             last_start3 = -1;
    int             cyc = 0;
    int             n_cmp = 0;
    int             n_err = 0;
    exp_t           exp_q [$];
    exp_t           e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            localparam int unsigned LSB = (g == 1) ? 39 : (g == 2) ? 40 : 10;
            localparam int unsigned SP  = (g == 3) ? PER_FAST : PER;
            adc0804_bcd_ctrl #(
                .SAMPLE_PERIOD (SP),
                .WR_CYCLES     (8),
                .RD_CYCLES     (8),
                .TIMEOUT_CYCLES(TMO),
                .LSB_TENTHS    (LSB)
            ) u_dut (
                .clk       (clk),
                .rst       (rst),
                .adc_data  (adc_data[g]),
                .adc_intr_n(intr_n[g]),
                .adc_cs_n  (cs_n[g]),
                .adc_wr_n  (wr_n[g]),
                .adc_rd_n  (rd_n[g]),
                .bcd       (bcd[g]),
                .bcd_valid (bcd_valid[g]),
                .busy      (busy[g]),
                .timeout   (tmo[g])
            );
        end
    endgenerate

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input int g, input int budget);
        int n0;
        int k;
        n0 = valid_cnt[g];
        k  = 0;
        while (valid_cnt[g] == n0 && k < budget) begin
            step(1);
            k++;
        end
        check("valid_arrived", 32'(valid_cnt[g] != n0), 1);
    endtask

    task automatic wait_rd(input int g, input logic lvl, input int budget);
        int k;
        k = 0;
        while (rd_n[g] !== lvl && k < budget) begin
            step(1);
            k++;
        end
        check("rd_level_reached", 32'(rd_n[g]), 32'(lvl));
    endtask

    // ADC0804 model: INTR falls ADC_DLY cycles after WR rises, and is released by RD low.
    always begin
        @(posedge clk);
        #1;
        for (int g = 0; g < N; g++) begin
            if (rst || !adc_en[g]) begin
                dly[g]    = 0;
                intr_n[g] = 1'b1;
            end else begin
                if (!rd_n[g]) intr_n[g] = 1'b1;
                if (dly[g] > 0) begin
                    dly[g]--;
                    if (dly[g] == 0) begin
                        intr_n[g] = 1'b0;
                        t_intr[g] = cyc;
                    end
                end
                if (!wr_q[g] && wr_n[g]) dly[g] = ADC_DLY;
            end
            wr_q[g] = wr_n[g];
        end
    end

    // Output monitor: strobe widths, start spacing and the expected-value queue.
    always @(negedge clk) begin
        if (rst) begin
            last_start3 = -1;
        end else begin
            for (int g = 0; g < N; g++) begin
                if (!wr_n[g]) begin
                    if (wr_run[g] == 0 && g == 3) begin
                        if (chk_fast) begin
                            check("fast_start_not_busy", 32'(busy_q[g]), 0);
                            if (last_start3 >= 0)
                                check("fast_start_on_wrap", 32'((cyc - last_start3) % PER_FAST), 0);
                        end
                        last_start3 = cyc;
                    end
                    wr_run[g]++;
                end else if (wr_run[g] > 0) begin
                    wr_w[g]   = wr_run[g];
                    wr_run[g] = 0;
                end
                if (!rd_n[g]) begin
                    rd_run[g]++;
                end else if (rd_run[g] > 0) begin
                    rd_w[g]   = rd_run[g];
                    rd_run[g] = 0;
                end
                if (bcd_valid[g]) begin
                    valid_cnt[g]++;
                    t_valid[g] = cyc;
                    check("valid_single_cycle", 32'(valid_q[g]), 0);
                    if (g == 3) begin
                        check("fast_bcd", 32'(bcd[g]), 32'h0370);
                    end else begin
                        check("sb_pending", 32'(exp_q.size() > 0), 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            check("sb_inst", g, e.idx);
                            check("sb_bcd", 32'(bcd[g]), 32'(e.val));
                        end
                    end
                end
            end
        end
        busy_q  = busy;
        valid_q = bcd_valid;
    end

    initial begin
        int t_rel;
        int t1;
        int n0;
        for (int g = 0; g < N; g++) begin
            adc_data[g]  = 8'd0;
            wr_run[g]    = 0;
            rd_run[g]    = 0;
            wr_w[g]      = 0;
            rd_w[g]      = 0;
            t_intr[g]    = 0;
            t_valid[g]   = 0;
            valid_cnt[g] = 0;
            dly[g]       = 0;
        end
        step(3);
        check("rst_strobes", 32'({cs_n[0], wr_n[0], rd_n[0]}), 32'h7);
        check("rst_bcd", 32'(bcd[0]), 0);
        check("rst_flags", 32'({bcd_valid[0], busy[0], tmo[0]}), 0);

        // Timeout: INTR never asserts on instance 0.
        rst   = 1'b0;
        t_rel = cyc;
        step(1);
        check("wr_low_first_cycle", 32'({cs_n[0], wr_n[0]}), 0);
        check("start_cycle", 32'(cyc - t_rel), 1);
        step(8);
        check("wr_released", 32'(wr_n[0]), 1);
        check("wr_width", 32'(wr_w[0]), 8);
        check("cs_held_wait", 32'(cs_n[0]), 0);
        step(999);
        check("timeout_not_early", 32'(tmo[0]), 0);
        step(1);
        check("timeout_set", 32'(tmo[0]), 1);
        check("timeout_cs_high", 32'(cs_n[0]), 1);
        check("timeout_bcd_kept", 32'(bcd[0]), 0);
        check("timeout_no_valid", 32'(valid_cnt[0]), 0);

        // Normal conversion of code 37.
        adc_data[0] = 8'd37;
        adc_en[0]   = 1'b1;
        exp_q.push_back('{idx: 0, val: 16'h0370});
        wait_valid(0, 1500);
        check("latency", 32'(t_valid[0] - t_intr[0]), LAT);
        check("rd_width", 32'(rd_w[0]), 8);
        check("timeout_cleared", 32'(tmo[0]), 0);
        step(2);
        check("bcd_held", 32'(bcd[0]), 32'h0370);
        check("one_valid", 32'(valid_cnt[0]), 1);

        // Full-scale then zero, one sample period apart.
        adc_data[0] = 8'd255;
        exp_q.push_back('{idx: 0, val: 16'h2550});
        wait_valid(0, 400);
        t1          = t_valid[0];
        adc_data[0] = 8'd0;
        exp_q.push_back('{idx: 0, val: 16'h0000});
        wait_valid(0, 400);
        check("valid_spacing", 32'(t_valid[0] - t1), PER);
        check("valid_count", 32'(valid_cnt[0]), 3);
        adc_en[0] = 1'b0;

        // 39 tenths per LSB: largest legal product and a single LSB.
        adc_data[1] = 8'd255;
        adc_en[1]   = 1'b1;
        exp_q.push_back('{idx: 1, val: 16'h9945});
        wait_valid(1, 2500);
        adc_data[1] = 8'd1;
        exp_q.push_back('{idx: 1, val: 16'h0039});
        wait_valid(1, 400);
        adc_en[1] = 1'b0;

        // 40 tenths per LSB: just over the display range saturates, just under does not.
        adc_data[2] = 8'd250;
        adc_en[2]   = 1'b1;
        exp_q.push_back('{idx: 2, val: 16'h9999});
        wait_valid(2, 2500);
        adc_data[2] = 8'd249;
        exp_q.push_back('{idx: 2, val: 16'h9960});
        wait_valid(2, 400);
        adc_en[2] = 1'b0;

        // Reset during READ and during CONVERT.
        adc_data[0] = 8'd37;
        adc_en[0]   = 1'b1;
        exp_q.push_back('{idx: 0, val: 16'h0370});
        wait_valid(0, 2500);
        n0 = valid_cnt[0];
        wait_rd(0, 1'b0, 400);
        step(3);
        rst = 1'b1;
        #1;
        check("rst_read_strobes", 32'({cs_n[0], wr_n[0], rd_n[0]}), 32'h7);
        check("rst_read_bcd", 32'(bcd[0]), 0);
        check("rst_read_flags", 32'({bcd_valid[0], busy[0]}), 0);
        step(2);
        rst = 1'b0;
        wait_rd(0, 1'b0, 400);
        wait_rd(0, 1'b1, 50);
        step(4);
        rst = 1'b1;
        #1;
        check("rst_conv_strobes", 32'({cs_n[0], wr_n[0], rd_n[0]}), 32'h7);
        check("rst_conv_bcd", 32'(bcd[0]), 0);
        check("rst_conv_flags", 32'({bcd_valid[0], busy[0]}), 0);
        step(2);
        check("rst_no_valid", 32'(valid_cnt[0]), 32'(n0));
        rst = 1'b0;
        exp_q.push_back('{idx: 0, val: 16'h0370});
        wait_valid(0, 600);
        check("resume_bcd", 32'(bcd[0]), 32'h0370);
        adc_en[0] = 1'b0;

        // Sample period shorter than a conversion: starts only from IDLE on a wrap.
        adc_data[3] = 8'd37;
        adc_en[3]   = 1'b1;
        chk_fast    = 1'b1;
        n0          = valid_cnt[3];
        step(2500);
        chk_fast  = 1'b0;
        adc_en[3] = 1'b0;
        check("fast_progress", 32'((valid_cnt[3] - n0) >= 5), 1);
        step(200);
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adc0804_bcd_ctrl.md
Name: adc0804_bcd_ctrl

Overview:
Upstream acquisition stage for the LM35 temperature display path. It drives an ADC0804 through its conversion handshake (cs_n/wr_n/rd_n/intr_n) and samples the 8-bit result. It scales the result to tenths of a degree and converts it to four packed BCD digits using sequential double-dabble. The LCD controller downstream consumes the BCD word and a done/busy indication.

Parameters:
SAMPLE_PERIOD, 5_000_000, clk cycles from one conversion start to the next (minimum: one full cycle of the FSM).
WR_CYCLES, 8, width of the wr_n low pulse in clk cycles (>=1).
RD_CYCLES, 8, width of the rd_n low pulse in clk cycles; data is latched on its last cycle (>=1).
TIMEOUT_CYCLES, 100_000, maximum number of clk cycles spent waiting for intr_n before the conversion is aborted.
LSB_TENTHS, 10, tenths of a degree C per ADC LSB (legal range 1..39).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
adc_data  in  8  ADC0804 DB7..DB0
adc_intr_n  in  1  ADC0804 INTR, active low, asynchronous to clk
adc_cs_n  out  1  ADC chip select, active low
adc_wr_n  out  1  ADC start-conversion strobe, active low
adc_rd_n  out  1  ADC output-enable/read strobe, active low
bcd  out  16  [15:12] hundreds, [11:8] tens, [7:4] units, [3:0] tenths
bcd_valid  out  1  one-cycle pulse when bcd updates
busy  out  1  high while a conversion or BCD conversion is in progress
timeout  out  1  sticky flag; set on intr_n timeout, cleared on the next successful update

Behaviour:
- Reset (async, rst=1): adc_cs_n=1, adc_wr_n=1, adc_rd_n=1, bcd=16'h0000, bcd_valid=0, busy=0, timeout=0. State=IDLE, all counters=0, synchroniser=2'b11. A reset asserted in any state aborts the operation immediately; strobes return high with no glitch beyond the async reset.
- adc_intr_n passes through a 2-FF synchroniser before use. The FSM acts on the synchronised value only.
- Period counter: free-running, counts 0..SAMPLE_PERIOD-1, and is independent of the FSM.
- IDLE: all strobes high, busy=0. Go to START on the cycle the period counter equals 0.
- START: cs_n=0, wr_n=0 for exactly WR_CYCLES cycles, then go to WAIT_INTR with wr_n=1 and cs_n=0 held.
- WAIT_INTR: on synchronised intr_n=0, go to READ. If TIMEOUT_CYCLES elapse first: set timeout=1, drive cs_n=1, go to IDLE, and leave bcd unchanged. intr_n low during START is ignored.
- READ: rd_n=0, cs_n=0 for RD_CYCLES cycles. On the last cycle adc_data is captured into code[7:0]. Next cycle: rd_n=1, cs_n=1, go to CONVERT.
- CONVERT: value = code*LSB_TENTHS, 14 bits unsigned, saturated to 9999 if larger. Double-dabble runs one shift per cycle for 14 cycles, with add-3 applied to each nibble >=5 before each shift.
- UPDATE: load bcd from the shifter, pulse bcd_valid for 1 cycle, clear timeout, go to IDLE.
- busy=1 in START, WAIT_INTR, READ, CONVERT, and UPDATE.
- Latency: from synchronised intr_n low to bcd_valid is RD_CYCLES+1+14+1 cycles.
- bcd is held stable at all times except the UPDATE edge. The downstream stage may sample it at any time.
- If the period counter wraps to 0 while busy, that start is skipped; the next start is at the following wrap.
- adc_intr_n stuck low while in IDLE causes no action until after the next START.

Test Plan:
- Reset, then release; hold adc_intr_n=1. Required: wr_n pulses low for 8 cycles at cycle 0. After 100000 cycles, timeout=1, bcd=16'h0000, bcd_valid never pulses.
- ADC model asserts intr_n 50 cycles after wr_n rises, with adc_data=8'd37. Required: rd_n low for 8 cycles, bcd=16'h0370, bcd_valid pulses exactly once, timeout clears. Check the intr_n-to-valid latency equals 2 sync cycles + 24.
- adc_data=8'd255, then a second conversion with 8'd0. Required: bcd=16'h2550, then 16'h0000, with one valid pulse each, SAMPLE_PERIOD apart.
- LSB_TENTHS=39 and adc_data=8'd255 (product 9945); then code 8'd1. Required: bcd=16'h9945, then 16'h0039. Add a forced-overflow check with saturation to 16'h9999.
- Assert rst during CONVERT and during READ. Required: all strobes=1 and bcd=16'h0000 asynchronously, with no bcd_valid pulse. Normal operation resumes at the next period wrap.
- Set SAMPLE_PERIOD shorter than the conversion time. Required: overlapping start requests are skipped, and no wr_n pulse is ever issued while busy=1.
